despejo_registradores: RTL and testbench
========================================

# despejo_registradores

Debug dump engine for the 8-bit nRisc core. On a start request it walks the register bank's read port from register 0 to the last register, captures each value, and transmits it on a single serial line as a UART 8N1 frame. It is the read-side counterpart to the core's register write path: the core writes the bank, this block reads it out to an external host. It sits beside the bank on a spare read port and never writes to it.

## Interface
- NUM_REGS, 16, number of registers scanned (2..16)
- ADDR_W, 4, register address width
- DATA_W, 8, register data width; the frame carries exactly DATA_W data bits
- CLKS_PER_BIT, 16, Clock cycles per serial bit (>= 2)

- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Iniciar  in  1  start request, sampled only in OCIOSO
- RegLido  out  ADDR_W  read address to the bank's read port
- DadoLido  in  DATA_W  combinational read data returned by the bank for RegLido
- Tx  out  1  serial output, idle high
- Ocupado  out  1  high from the cycle after Iniciar is accepted until Pronto
- Pronto  out  1  one-cycle pulse when the dump completes

## Operation
- States: OCIOSO, ENDERECA, INICIO, DADOS, PARADA, FIM.
- OCIOSO: Tx=1, Ocupado=0, RegLido=0. Iniciar=1 -> ENDERECA with index=0.
- ENDERECA: RegLido=index. At the end of this cycle, capture DadoLido into the shift register -> INICIO.
- INICIO: Tx=0 for CLKS_PER_BIT cycles -> DADOS with bit count=0.
- DADOS: Tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After DATA_W bits -> PARADA.
- PARADA: Tx=1 for CLKS_PER_BIT cycles.
  - If index == NUM_REGS-1 -> FIM.
  - Otherwise index+1 -> ENDERECA.
- FIM: Pronto=1 and Ocupado=1 for one cycle -> OCIOSO.
- Iniciar is ignored in every state except OCIOSO. It is not queued.
- Captured data is frozen for the whole frame. Changes on DadoLido after capture do not affect Tx.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide and resets to 0 on every state or bit change.
- Index never exceeds NUM_REGS-1. RegLido returns to 0 in OCIOSO.

## Timing
- Reset (async, Reset=0): immediately Tx=1, Ocupado=0, Pronto=0, RegLido=0, state=OCIOSO, counters=0. This holds even mid-frame. No partial frame resumes after reset.
- Reset release: the first active edge is the first edge after Reset=1.
- Iniciar high at the edge ending cycle N (in OCIOSO):
  - Cycle N+1 is ENDERECA, with Ocupado=1 and RegLido=0.
  - The start bit begins at cycle N+2.
- Per register: 1 + (DATA_W+2)·CLKS_PER_BIT cycles.
- Pronto is asserted in cycle N+1+NUM_REGS·(1+(DATA_W+2)·CLKS_PER_BIT).
- For defaults with CLKS_PER_BIT=4, Pronto is at N+657.
- All outputs are registered except RegLido, which may be combinational from index and state.
- Iniciar high during the Pronto cycle is ignored. Iniciar high in the following OCIOSO cycle starts a new dump.

## Test plan
- Reset: hold Reset=0 and drive random Iniciar -> Tx=1, Ocupado=0, Pronto=0, RegLido=0. Then assert Reset=0 asynchronously mid-frame -> Tx=1 within the same cycle with no clock edge, and the state returns to OCIOSO.
- Full dump (CLKS_PER_BIT=4): bank model holds reg k = 0x10+k, reg 0 = 0xA5; pulse Iniciar.
  - Reg 0 frame Tx sequence: 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - Host-side decoder receives 0xA5, 0x11 … 0x1F in order.
  - Pronto is a single pulse 657 cycles after acceptance.
- Capture freeze: change DadoLido for the current address from 0x3C to 0xFF two cycles into INICIO -> the frame still carries 0x3C.
- Busy ignore: pulse Iniciar at cycles 50, 200 and 655 of a dump -> exactly 16 frames are sent and exactly one Pronto.
- Restart: Iniciar held high continuously -> the second dump's ENDERECA begins 2 cycles after Pronto (one OCIOSO cycle, then ENDERECA). No frame overlaps the previous dump's stop bit.
- Parameter corner: NUM_REGS=2, CLKS_PER_BIT=2 -> 2 frames, each 21 cycles. Pronto is at N+43. RegLido never exceeds 1.

Source files
------------

// File: rtl/despejo_registradores.sv
`default_nettype none
// ============================================================================
//  Module      : despejo_registradores
//  Description : Register-bank dump engine. On Iniciar it reads registers
//                0..NUM_REGS-1 through a spare read port and sends each value
//                on Tx as a UART 8N1-style frame. The data is sent LSB first,
//                with one start bit and one stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module despejo_registradores #(
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Iniciar,
    output logic [ADDR_W-1:0] RegLido,
    input  logic [DATA_W-1:0] DadoLido,
    output logic              Tx,
    output logic              Ocupado,
    output logic              Pronto
);

    // Bit-period counter width: ceil(log2(CLKS_PER_BIT)), at least one bit.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Data-bit counter spans 0..DATA_W-1.
    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_BIT_MAX = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] c_IDX_MAX = ADDR_W'(NUM_REGS - 1);

    localparam logic [2:0] c_OCIOSO   = 3'd0;
    localparam logic [2:0] c_ENDERECA = 3'd1;
    localparam logic [2:0] c_INICIO   = 3'd2;
    localparam logic [2:0] c_DADOS    = 3'd3;
    localparam logic [2:0] c_PARADA   = 3'd4;
    localparam logic [2:0] c_FIM      = 3'd5;

    logic [2:0]        r_estado;
    logic [ADDR_W-1:0] r_indice;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_ocupado;
    logic              r_pronto;

    logic [2:0]        w_estadoProx;
    logic [ADDR_W-1:0] w_indiceProx;
    logic [CNT_W-1:0]  w_cntProx;
    logic [BIT_W-1:0]  w_bitProx;
    logic [DATA_W-1:0] w_shiftProx;
    logic              w_txProx;
    logic              w_ocupadoProx;
    logic              w_prontoProx;
    logic              w_fimPeriodo;

    assign w_fimPeriodo = (r_cnt == c_CNT_MAX);

    // Sequencer: walks address -> start bit -> data bits -> stop bit per register.
    always_comb begin
        w_estadoProx = r_estado;
        w_indiceProx = r_indice;
        w_cntProx    = r_cnt;
        w_bitProx    = r_bit;
        w_shiftProx  = r_shift;
        case (r_estado)
            c_OCIOSO: begin
                w_indiceProx = '0;
                w_cntProx    = '0;
                w_bitProx    = '0;
                if (Iniciar) begin
                    w_estadoProx = c_ENDERECA;
                end
            end
            c_ENDERECA: begin
                // Snapshot taken here; the frame never looks at DadoLido again.
                w_shiftProx  = DadoLido;
                w_cntProx    = '0;
                w_estadoProx = c_INICIO;
            end
            c_INICIO: begin
                if (w_fimPeriodo) begin
                    w_cntProx    = '0;
                    w_bitProx    = '0;
                    w_estadoProx = c_DADOS;
                end else begin
                    w_cntProx = r_cnt + CNT_W'(1);
                end
            end
            c_DADOS: begin
                if (w_fimPeriodo) begin
                    w_cntProx   = '0;
                    w_shiftProx = {1'b0, r_shift[DATA_W-1:1]};
                    if (r_bit == c_BIT_MAX) begin
                        w_estadoProx = c_PARADA;
                    end else begin
                        w_bitProx = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_cntProx = r_cnt + CNT_W'(1);
                end
            end
            c_PARADA: begin
                if (w_fimPeriodo) begin
                    w_cntProx = '0;
                    if (r_indice == c_IDX_MAX) begin
                        w_estadoProx = c_FIM;
                    end else begin
                        w_indiceProx = r_indice + ADDR_W'(1);
                        w_estadoProx = c_ENDERECA;
                    end
                end else begin
                    w_cntProx = r_cnt + CNT_W'(1);
                end
            end
            c_FIM: begin
                w_indiceProx = '0;
                w_estadoProx = c_OCIOSO;
            end
            default: begin
                w_indiceProx = '0;
                w_cntProx    = '0;
                w_bitProx    = '0;
                w_estadoProx = c_OCIOSO;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        w_txProx = 1'b1;
        case (w_estadoProx)
            c_INICIO: w_txProx = 1'b0;
            c_DADOS:  w_txProx = w_shiftProx[0];
            default:  w_txProx = 1'b1;
        endcase
        w_ocupadoProx = (w_estadoProx != c_OCIOSO);
        w_prontoProx  = (w_estadoProx == c_FIM);
    end

    // State and registered outputs; reset forces an idle line at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_estado  <= c_OCIOSO;
            r_indice  <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_estado  <= w_estadoProx;
            r_indice  <= w_indiceProx;
            r_cnt     <= w_cntProx;
            r_bit     <= w_bitProx;
            r_shift   <= w_shiftProx;
            r_tx      <= w_txProx;
            r_ocupado <= w_ocupadoProx;
            r_pronto  <= w_prontoProx;
        end
    end

    // Read address goes back to register 0 whenever the engine is idle.
    assign RegLido = (r_estado == c_OCIOSO) ? '0 : r_indice;
    assign Tx      = r_tx;
    assign Ocupado = r_ocupado;
    assign Pronto  = r_pronto;

endmodule
`default_nettype wire

// File: tb/tb_despejo_registradores.sv
`default_nettype none
// ============================================================================
//  Module      : tb_despejo_registradores
//  Description : Self-checking bench for despejo_registradores. Instance A is
//                16 regs / 4 clocks per bit, instance B is 2 regs / 2 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_despejo_registradores;

    localparam int NRA = 16;
    localparam int CA  = 4;
    localparam int NRB = 2;
    localparam int CB  = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iniA  = 1'b0;
    logic       iniB  = 1'b0;
    logic [3:0] regA, regB;
    logic [7:0] dadoA, dadoB;
    logic       txA, ocA, prA, txB, ocB, prB;

    logic [7:0] bankA [16];
    logic [7:0] bankB [16];

    int assertCount = 0;
    int failCount   = 0;

    always #5 Clock = ~Clock;

    assign dadoA = bankA[regA];
    assign dadoB = bankB[regB];

    despejo_registradores #(.NUM_REGS(NRA), .ADDR_W(4), .DATA_W(8), .CLKS_PER_BIT(CA)) dutA (
        .Clock(Clock), .Reset(Reset), .Iniciar(iniA), .RegLido(regA),
        .DadoLido(dadoA), .Tx(txA), .Ocupado(ocA), .Pronto(prA)
    );

    despejo_registradores #(.NUM_REGS(NRB), .ADDR_W(4), .DATA_W(8), .CLKS_PER_BIT(CB)) dutB (
        .Clock(Clock), .Reset(Reset), .Iniciar(iniB), .RegLido(regB),
        .DadoLido(dadoB), .Tx(txB), .Ocupado(ocB), .Pronto(prB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: cycle offset within a dump ----------
    // t = 0 idle; t = 1 is the first address cycle; t = 1+nr*L is the done cycle.
    function automatic int lenF(input int c);
        return 1 + 10 * c;
    endfunction

    function automatic logic expTx(input int t, input int nr, input int c, input logic [7:0] d);
        int L, p, b;
        L = lenF(c);
        if (t == 0 || t >= 1 + nr * L) return 1'b1;
        p = (t - 1) % L;
        if (p == 0) return 1'b1;
        b = (p - 1) / c;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    int         tA = 0, tB = 0;
    logic [7:0] capA [16];
    logic [7:0] capB [16];

    initial begin
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                tA = 0;
                tB = 0;
            end else begin
                if (tA == 0) begin
                    if (iniA) tA = 1;
                end else if (tA == 1 + NRA * lenF(CA)) begin
                    tA = 0;
                end else begin
                    if ((tA - 1) % lenF(CA) == 0) capA[(tA-1)/lenF(CA)] = bankA[(tA-1)/lenF(CA)];
                    tA++;
                end
                if (tB == 0) begin
                    if (iniB) tB = 1;
                end else if (tB == 1 + NRB * lenF(CB)) begin
                    tB = 0;
                end else begin
                    if ((tB - 1) % lenF(CB) == 0) capB[(tB-1)/lenF(CB)] = bankB[(tB-1)/lenF(CB)];
                    tB++;
                end
            end
        end
    end

    task automatic cmpDut(input string tag, input int t, input int nr, input int c,
                          input logic [7:0] d, input logic tx, input logic oc,
                          input logic pr, input logic [3:0] rl);
        int L, tot;
        L   = lenF(c);
        tot = 1 + nr * L;
        chk({tag, ".Tx"}, 32'(tx), 32'(expTx(t, nr, c, d)));
        chk({tag, ".Ocupado"}, 32'(oc), (t != 0) ? 32'd1 : 32'd0);
        chk({tag, ".Pronto"}, 32'(pr), (t == tot) ? 32'd1 : 32'd0);
        if (t == 0) chk({tag, ".RegLidoIdle"}, 32'(rl), 32'd0);
        else if (t < tot && (t - 1) % L == 0) chk({tag, ".RegLidoAddr"}, 32'(rl), 32'((t - 1) / L));
        chk({tag, ".RegLidoRange"}, (int'(rl) <= nr - 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        int k;
        forever begin
            @(negedge Clock);
            k = (tA > 0 && tA < 1 + NRA * lenF(CA)) ? (tA - 1) / lenF(CA) : 0;
            cmpDut("A", tA, NRA, CA, capA[k], txA, ocA, prA, regA);
            k = (tB > 0 && tB < 1 + NRB * lenF(CB)) ? (tB - 1) / lenF(CB) : 0;
            cmpDut("B", tB, NRB, CB, capB[k], txB, ocB, prB, regB);
        end
    end

    // ---------------- host-side receiver on instance A ----------------------
    logic [7:0] rxQ [$];

    initial begin
        int         dCnt;
        logic       dBusy;
        logic [7:0] dByte;
        dBusy = 1'b0;
        dCnt  = 0;
        dByte = 8'h00;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                dBusy = 1'b0;
            end else if (!dBusy) begin
                if (txA == 1'b0) begin
                    dBusy = 1'b1;
                    dCnt  = 0;
                end
            end else begin
                dCnt++;
                if (dCnt >= CA + CA / 2 && dCnt < 9 * CA && (dCnt - CA / 2) % CA == 0)
                    dByte[(dCnt - CA / 2) / CA - 1] = txA;
                if (dCnt == 9 * CA + CA / 2) begin
                    chk("rx.stopBit", 32'(txA), 32'd1);
                    rxQ.push_back(dByte);
                    dBusy = 1'b0;
                end
            end
        end
    end

    // ---------------- recording helper for instance A -----------------------
    logic txRec [800];
    logic prRec [800];
    logic ocRec [800];

    // Index 0 is the cycle right after the edge that accepts Iniciar.
    task automatic recordA(input int ncyc, input int p1, input int p2, input int p3,
                           input int p4, input logic hold, input int chgAt);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clock);
            txRec[i] = txA;
            prRec[i] = prA;
            ocRec[i] = ocA;
            iniA = hold || i == p1 || i == p2 || i == p3 || i == p4;
            if (i == chgAt) bankA[0] = 8'hFF;
        end
    endtask

    function automatic int countPronto(input int ncyc, output int where);
        int n;
        n = 0;
        where = -1;
        for (int i = 0; i < ncyc; i++) if (prRec[i]) begin n++; where = i; end
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus -------------------------------------
    initial begin
        int         q0, nP, wP, rlMaxB, nPB, wPB;
        logic [9:0] seqLit;
        logic       prB_r [64];
        logic       ocB_r [64];
        logic       txB_r [64];

        for (int k = 0; k < 16; k++) begin
            bankA[k] = 8'(8'h10 + k);
            bankB[k] = 8'hEE;
            capA[k]  = 8'h00;
            capB[k]  = 8'h00;
        end
        bankA[0] = 8'hA5;
        bankB[0] = 8'h5A;
        bankB[1] = 8'hC3;

        // Reset held with random start requests.
        Reset = 1'b0;
        repeat (8) begin
            @(negedge Clock);
            iniA = 1'($urandom_range(0, 1));
            iniB = 1'($urandom_range(0, 1));
            chk("rst.Tx", 32'(txA), 32'd1);
            chk("rst.Ocupado", 32'(ocA), 32'd0);
            chk("rst.Pronto", 32'(prA), 32'd0);
            chk("rst.RegLido", 32'(regA), 32'd0);
        end
        @(negedge Clock);
        iniA  = 1'b0;
        iniB  = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);

        // Full dump.
        q0   = rxQ.size();
        iniA = 1'b1;
        recordA(700, -1, -1, -1, -1, 1'b0, -1);
        nP = countPronto(700, wP);
        chk("full.prontoCount", 32'(nP), 32'd1);
        chk("full.prontoCycle", 32'(wP + 1), 32'd657);
        seqLit = 10'b1101001010;
        for (int b = 0; b < 10; b++) chk("full.reg0Bit", 32'(txRec[2 + 4 * b]), 32'(seqLit[b]));
        chk("full.frames", 32'(rxQ.size() - q0), 32'd16);
        for (int k = 0; k < 16 && q0 + k < rxQ.size(); k++)
            chk("full.rxByte", 32'(rxQ[q0 + k]), (k == 0) ? 32'hA5 : 32'(8'h10 + k));

        // Capture freeze: register 0 changes two cycles into the start bit.
        bankA[0] = 8'h3C;
        q0       = rxQ.size();
        iniA     = 1'b1;
        recordA(700, -1, -1, -1, -1, 1'b0, 3);
        chk("freeze.inStartBit", 32'(txRec[3]), 32'd0);
        chk("freeze.frames", 32'(rxQ.size() - q0), 32'd16);
        if (rxQ.size() > q0) chk("freeze.rxByte0", 32'(rxQ[q0]), 32'h3C);
        bankA[0] = 8'hA5;

        // Busy ignore: requests during the dump and in the Pronto cycle.
        q0   = rxQ.size();
        iniA = 1'b1;
        recordA(700, 50, 200, 655, 656, 1'b0, -1);
        nP = countPronto(700, wP);
        chk("busy.prontoCount", 32'(nP), 32'd1);
        chk("busy.prontoCycle", 32'(wP), 32'd656);
        chk("busy.idleAfter", 32'(ocRec[657]), 32'd0);
        chk("busy.idleLate", 32'(ocRec[699]), 32'd0);
        chk("busy.frames", 32'(rxQ.size() - q0), 32'd16);

        // Restart with Iniciar held high.
        q0   = rxQ.size();
        iniA = 1'b1;
        recordA(700, -1, -1, -1, -1, 1'b1, -1);
        iniA = 1'b0;
        chk("restart.pronto", 32'(prRec[656]), 32'd1);
        chk("restart.oneIdle", 32'(ocRec[657]), 32'd0);
        chk("restart.busyAgain", 32'(ocRec[658]), 32'd1);
        chk("restart.stopHigh", 32'({txRec[656], txRec[657], txRec[658]}), 32'd7);
        chk("restart.newStart", 32'(txRec[659]), 32'd0);
        repeat (700) @(negedge Clock);
        chk("restart.frames", 32'(rxQ.size() - q0), 32'd32);

        // Asynchronous reset in the middle of a start bit.
        q0   = rxQ.size();
        iniA = 1'b1;
        recordA(3, -1, -1, -1, -1, 1'b0, -1);
        chk("areset.preTx", 32'(txRec[2]), 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("areset.Tx", 32'(txA), 32'd1);
        chk("areset.Ocupado", 32'(ocA), 32'd0);
        chk("areset.Pronto", 32'(prA), 32'd0);
        chk("areset.RegLido", 32'(regA), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (50) @(negedge Clock);
        chk("areset.noFrame", 32'(rxQ.size() - q0), 32'd0);

        // Parameter corner: 2 registers, 2 clocks per bit.
        iniB   = 1'b1;
        rlMaxB = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clock);
            prB_r[i] = prB;
            ocB_r[i] = ocB;
            txB_r[i] = txB;
            if (int'(regB) > rlMaxB) rlMaxB = int'(regB);
            iniB = 1'b0;
        end
        nPB = 0;
        wPB = -1;
        for (int i = 0; i < 64; i++) if (prB_r[i]) begin nPB++; wPB = i; end
        chk("corner.prontoCount", 32'(nPB), 32'd1);
        chk("corner.prontoCycle", 32'(wPB + 1), 32'd43);
        chk("corner.idleAfter", 32'(ocB_r[43]), 32'd0);
        chk("corner.regMax", 32'(rlMaxB), 32'd1);
        chk("corner.start0", 32'(txB_r[1]), 32'd0);
        chk("corner.bit0", 32'(txB_r[3]), 32'd0);
        chk("corner.bit1", 32'(txB_r[5]), 32'd1);
        chk("corner.addr1", 32'(txB_r[21]), 32'd1);
        chk("corner.start1", 32'(txB_r[22]), 32'd0);
        chk("corner.r1bit0", 32'(txB_r[24]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
